// File: rtl/output_port_arbiter.sv
// Round-robin output-port arbiter: grants one requester a burst of beats
// and registers the accepted beat onto the pad output-register D inputs.
module output_port_arbiter #(
    parameter int               N_REQ      = 4,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE_VALUE = '0,
    parameter int               MAX_BURST  = 4,
    localparam int              GW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clock,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       out_d,
    output logic                   out_valid,
    output logic [GW-1:0]          grant_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_q, last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] data_a [N_REQ];
    logic             rr_found;
    logic [GW-1:0]    rr_pick;
    logic [GW-1:0]    rr_idx;
    logic [8:0]       cnt_inc;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_a[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_idx = GW'((int'(last_q) + k) % N_REQ);
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        data_d    = IDLE_VALUE;
        valid_d   = 1'b0;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    cnt_d   = 8'd0;
                    state_d = BURST;
                end
            end
            BURST: begin
                req_ready[grant_q] = 1'b1;
                if (req_valid[grant_q]) begin
                    data_d  = data_a[grant_q];
                    valid_d = 1'b1;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_inc[7:0];
                    // last flag and beat limit on the same beat end the burst once
                    if (req_last[grant_q] || cnt_inc == 9'(MAX_BURST)) begin
                        state_d = GAP;
                        last_d  = grant_q;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(N_REQ - 1);
            cnt_q   <= 8'd0;
            data_q  <= IDLE_VALUE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_d     = data_q;
    assign out_valid = valid_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: per-requester beat sources,
// cycle-by-cycle hand-computed expectations.
module tb_output_port_arbiter;

    localparam logic [7:0] IV = 8'hA5;

    logic        clock;
    logic        RESET;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  out_d;
    logic        out_valid;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int         src_left    [4];
    int         src_sent    [4];
    int         src_last_at [4];
    logic [7:0] src_data    [4];
    bit         src_lastall [4];
    bit         src_hold    [4];

    output_port_arbiter #(
        .N_REQ(4), .WIDTH(8), .IDLE_VALUE(IV), .MAX_BURST(4)
    ) dut (
        .clock    (clock),
        .RESET    (RESET),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .out_d    (out_d),
        .out_valid(out_valid),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]         = (src_left[i] > 0) && !src_hold[i];
            req_data[i*8 +: 8]   = src_data[i];
            req_last[i]          = src_lastall[i] ||
                (src_last_at[i] != 0 && src_sent[i] + 1 == src_last_at[i]);
        end
    endtask

    task automatic clr_src();
        for (int i = 0; i < 4; i++) begin
            src_left[i]    = 0;
            src_sent[i]    = 0;
            src_last_at[i] = 0;
            src_data[i]    = 8'h00;
            src_lastall[i] = 1'b0;
            src_hold[i]    = 1'b0;
        end
    endtask

    task automatic step(input string tag, input logic ov, input logic [7:0] d,
                        input logic bz, input logic [3:0] rdy,
                        input logic [1:0] gid);
        logic [3:0] hs;
        hs = req_valid & req_ready & {4{~RESET}};
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                src_data[i] = src_data[i] + 8'd1;
                src_left[i] = src_left[i] - 1;
                src_sent[i] = src_sent[i] + 1;
            end
        end
        drive();
        check({tag, ".valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".data"},  32'(out_d),     32'(d));
        check({tag, ".busy"},  32'(busy),      32'(bz));
        check({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        check({tag, ".gid"},   32'(grant_id),  32'(gid));
    endtask

    initial begin
        clock = 1'b0;
        RESET = 1'b1;
        clr_src();
        drive();
        step("rst0", 0, IV, 0, 4'b0000, 0);
        step("rst1", 0, IV, 0, 4'b0000, 0);

        // requesters 0 and 2, one-beat bursts
        RESET = 1'b0;
        src_left[0] = 2; src_data[0] = 8'h10; src_lastall[0] = 1;
        src_left[2] = 2; src_data[2] = 8'h30; src_lastall[2] = 1;
        drive();
        step("alt_g0", 0, IV,    1, 4'b0001, 0);
        step("alt_d0", 1, 8'h10, 1, 4'b0000, 0);
        step("alt_i0", 0, IV,    0, 4'b0000, 0);
        step("alt_g2", 0, IV,    1, 4'b0100, 2);
        step("alt_d2", 1, 8'h30, 1, 4'b0000, 2);
        step("alt_i2", 0, IV,    0, 4'b0000, 2);
        step("alt_g0b", 0, IV,    1, 4'b0001, 0);
        step("alt_d0b", 1, 8'h11, 1, 4'b0000, 0);
        step("alt_i0b", 0, IV,    0, 4'b0000, 0);
        step("alt_g2b", 0, IV,    1, 4'b0100, 2);
        step("alt_d2b", 1, 8'h31, 1, 4'b0000, 2);
        step("alt_i2b", 0, IV,    0, 4'b0000, 2);

        // requester 1: six beats, MAX_BURST splits them 4 + 2
        clr_src();
        src_left[1] = 6; src_data[1] = 8'h11;
        drive();
        step("mb_g",  0, IV,    1, 4'b0010, 1);
        step("mb_11", 1, 8'h11, 1, 4'b0010, 1);
        step("mb_12", 1, 8'h12, 1, 4'b0010, 1);
        step("mb_13", 1, 8'h13, 1, 4'b0010, 1);
        step("mb_14", 1, 8'h14, 1, 4'b0000, 1);
        step("mb_gap", 0, IV,   0, 4'b0000, 1);
        step("mb_g2", 0, IV,    1, 4'b0010, 1);
        step("mb_15", 1, 8'h15, 1, 4'b0010, 1);
        step("mb_16", 1, 8'h16, 1, 4'b0010, 1);
        step("mb_w0", 0, IV,    1, 4'b0010, 1);
        step("mb_w1", 0, IV,    1, 4'b0010, 1);
        RESET = 1'b1;
        step("mb_rst", 0, IV,   0, 4'b0000, 0);
        RESET = 1'b0;

        // requester 2 pauses three cycles after beat 2
        clr_src();
        src_left[2] = 4; src_data[2] = 8'h21;
        drive();
        step("ps_g",  0, IV,    1, 4'b0100, 2);
        step("ps_21", 1, 8'h21, 1, 4'b0100, 2);
        step("ps_22", 1, 8'h22, 1, 4'b0100, 2);
        src_hold[2] = 1; drive();
        step("ps_h0", 0, IV,    1, 4'b0100, 2);
        step("ps_h1", 0, IV,    1, 4'b0100, 2);
        step("ps_h2", 0, IV,    1, 4'b0100, 2);
        src_hold[2] = 0; drive();
        step("ps_23", 1, 8'h23, 1, 4'b0100, 2);
        step("ps_24", 1, 8'h24, 1, 4'b0000, 2);
        step("ps_i",  0, IV,    0, 4'b0000, 2);

        // requester 3: last flag on the same beat as the limit
        clr_src();
        src_left[3] = 8; src_data[3] = 8'h41; src_last_at[3] = 4;
        drive();
        step("lm_g",  0, IV,    1, 4'b1000, 3);
        step("lm_41", 1, 8'h41, 1, 4'b1000, 3);
        step("lm_42", 1, 8'h42, 1, 4'b1000, 3);
        step("lm_43", 1, 8'h43, 1, 4'b1000, 3);
        step("lm_44", 1, 8'h44, 1, 4'b0000, 3);
        step("lm_gap", 0, IV,   0, 4'b0000, 3);
        step("lm_g2", 0, IV,    1, 4'b1000, 3);
        step("lm_45", 1, 8'h45, 1, 4'b1000, 3);

        // reset during beat 2, then all four continuously valid
        RESET = 1'b1;
        clr_src();
        for (int i = 0; i < 4; i++) begin
            src_left[i]    = 2;
            src_lastall[i] = 1;
            src_data[i]    = 8'(8'h60 + i * 16);
        end
        drive();
        step("ab_rst", 0, IV, 0, 4'b0000, 0);
        RESET = 1'b0;
        drive();
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            step("rr_g", 0, IV, 1, 4'(1 << g), 2'(g));
            step("rr_d", 1, 8'(8'h60 + g * 16 + k / 4), 1, 4'b0000, 2'(g));
            step("rr_i", 0, IV, 0, 4'b0000, 2'(g));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
